// File: rtl/jk_count_seq_if.sv
// Control/status bundle between the jk excitation sequencer and its user/bank.
// Handshake: there is no valid/ready pairing; every signal is level-sampled on each clk rising edge and ready only reports RUN.
interface jk_count_seq_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             ready;
    logic             tc;
    logic             wrap;
    logic             err;
    logic             state_dbg;

    modport master (
        output en, up, load, din, q_in,
        input  j, k, ready, tc, wrap, err, state_dbg
    );

    modport slave (
        input  en, up, load, din, q_in,
        output j, k, ready, tc, wrap, err, state_dbg
    );
endinterface

// File: rtl/jk_count_seq.sv
// Computes J/K excitation for a reset-less jk flip-flop bank so it counts modulo MODULUS.
// Also clears the bank after reset, and flags wrap-around and illegal bank states.
module jk_count_seq #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input logic          clk,
    input logic          rst,
    jk_count_seq_if.slave bus
);
    localparam logic [0:0]       S_CLR = 1'b0;
    localparam logic [0:0]       S_RUN = 1'b1;
    localparam logic [WIDTH:0]   MOD   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAXW  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [0:0]       state_q, state_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   q_ext, din_ext;
    logic [WIDTH-1:0] nxt, j_c, k_c;
    logic             illegal, at_max, at_zero, ready_c, tc_c, clr;

    always_comb begin
        q_ext   = {1'b0, bus.q_in};
        din_ext = {1'b0, bus.din};
        illegal = (q_ext >= MOD);
        at_max  = (q_ext == MAX);
        at_zero = (q_ext == '0);
        ready_c = (state_q == S_RUN);
        tc_c    = ready_c & bus.en & ~bus.load & ~illegal & (bus.up ? at_max : at_zero);

        state_d = S_RUN;
        err_d   = err_q;
        wrap_d  = tc_c;
        nxt     = bus.q_in;
        clr     = 1'b0;

        if (state_q == S_CLR) begin
            clr = 1'b1;
        end else if (illegal) begin
            clr   = 1'b1;
            err_d = 1'b1;
        end else if (bus.load) begin
            // An out-of-range load value holds the count rather than being clipped.
            if (din_ext < MOD) nxt = bus.din;
            else               err_d = 1'b1;
        end else if (bus.en) begin
            if (bus.up) nxt = at_max  ? '0   : bus.q_in + ONE;
            else        nxt = at_zero ? MAXW : bus.q_in - ONE;
        end

        // Minimal JK form: only changing bits get J or K, never both.
        j_c = clr ? '0 : (nxt & ~bus.q_in);
        k_c = clr ? '1 : (~nxt & bus.q_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLR;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.j         = j_c;
    assign bus.k         = k_c;
    assign bus.ready     = ready_c;
    assign bus.tc        = tc_c;
    assign bus.wrap      = wrap_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_jk_count_seq.sv
// Bench for jk_count_seq: models the jk bank, drives directed then random stimulus,
// and scores every cycle's outputs against a counting-rule reference model.
module tb_jk_count_seq;
    localparam int W   = 4;
    localparam int MOD = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_count_seq_if #(.WIDTH(W)) bus ();

    jk_count_seq #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // jk bank model; force_en overrides the visible state for one cycle
    logic [W-1:0] q_bank;
    logic         force_en  = 1'b1;
    logic [W-1:0] force_val = 4'b1011;
    logic [W-1:0] q_cur;
    assign q_cur    = force_en ? force_val : q_bank;
    assign bus.q_in = q_cur;

    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            case ({bus.j[i], bus.k[i]})
                2'b10:   q_bank[i] <= 1'b1;
                2'b01:   q_bank[i] <= 1'b0;
                2'b11:   q_bank[i] <= ~q_cur[i];
                default: q_bank[i] <= q_cur[i];
            endcase
        end
    end

    // scoreboard: {q[15:12], j[11:8], k[7:4], ready, tc, wrap, err}
    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_run  = 1'b0;
    bit m_err  = 1'b0;
    bit m_wrap = 1'b0;
    int m_cnt  = 11;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit rst_v, input bit en_v, input bit up_v,
                        input bit load_v, input int din_v, input int force_v);
        int nxt, ej, ek;
        bit clr, tc_e, eset;
        @(negedge clk);
        rst      = rst_v;
        bus.en   = en_v;
        bus.up   = up_v;
        bus.load = load_v;
        bus.din  = W'(din_v);
        force_en = (force_v >= 0);
        if (force_v >= 0) begin
            force_val = W'(force_v);
            m_cnt     = force_v;
        end

        if (rst_v) begin
            m_run = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
        end
        clr  = !m_run || (m_cnt >= MOD);
        tc_e = 1'b0;
        eset = 1'b0;
        nxt  = m_cnt;
        if (clr) begin
            nxt  = 0;
            eset = m_run;
        end else if (load_v) begin
            if (din_v < MOD) nxt = din_v;
            else             eset = 1'b1;
        end else if (en_v) begin
            if (up_v) begin
                tc_e = (m_cnt == MOD - 1);
                nxt  = (m_cnt + 1) % MOD;
            end else begin
                tc_e = (m_cnt == 0);
                nxt  = (m_cnt + MOD - 1) % MOD;
            end
        end
        ej = clr ? 0  : (nxt & ~m_cnt & 15);
        ek = clr ? 15 : (~nxt & m_cnt & 15);
        exp_q.push_back({4'(m_cnt), 4'(ej), 4'(ek), m_run, tc_e, m_wrap, m_err});

        m_cnt  = nxt;
        m_wrap = rst_v ? 1'b0 : tc_e;
        m_err  = rst_v ? 1'b0 : (m_err | eset);
        m_run  = !rst_v;
    endtask

    // monitor: compares mid-cycle, well away from the rising edge
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("q",     int'(q_cur),     int'(e[15:12]));
                check("j",     int'(bus.j),     int'(e[11:8]));
                check("k",     int'(bus.k),     int'(e[7:4]));
                check("ready", int'(bus.ready), int'(e[3]));
                check("tc",    int'(bus.tc),    int'(e[2]));
                check("wrap",  int'(bus.wrap),  int'(e[1]));
                check("err",   int'(bus.err),   int'(e[0]));
            end
        end
    end

    initial begin
        int budget;
        bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.din = '0;

        // reset with the bank powered up at 1011, then the CLR cycle
        step(1, 0, 1, 0, 0, 11);
        step(1, 0, 1, 0, 0, -1);
        step(0, 0, 1, 0, 0, -1);
        // up through wrap, then down through wrap
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, -1);
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, -1);
        // load beats enable, illegal load, hold
        step(0, 1, 1, 1, 7, -1);
        step(0, 1, 1, 1, 12, -1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, -1);
        // illegal bank state then normal counting
        step(0, 1, 1, 0, 0, 13);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, -1);
        // load boundaries and mid-count async reset at q=5
        step(0, 0, 1, 1, 9, -1);
        step(0, 0, 1, 1, 10, -1);
        step(0, 0, 1, 1, 5, -1);
        step(1, 1, 1, 0, 0, -1);
        step(1, 1, 1, 0, 0, -1);
        step(0, 1, 1, 0, 0, -1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, -1);

        for (int i = 0; i < 400; i++) begin
            int r, f;
            r = $urandom_range(0, 99);
            f = ($urandom_range(0, 99) < 3) ? $urandom_range(MOD, 15) : -1;
            step(r < 2, $urandom_range(0, 99) < 75, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 12, $urandom_range(0, 15), f);
        end
        step(0, 0, 1, 0, 0, -1);

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
